// File: rtl/systolic_feeder_if.sv
// Load channel of the systolic feeder: one beat carries column k of both operands,
// lane i packed at bits [i*DATA_W +: DATA_W].
interface systolic_feeder_if #(
  parameter int LANES  = 4,
  parameter int DATA_W = 8
) ();
  logic                    ld_valid;
  logic                    ld_ready;
  logic [LANES*DATA_W-1:0] ld_a;
  logic [LANES*DATA_W-1:0] ld_b;

  modport master (output ld_valid, ld_a, ld_b, input ld_ready);
  modport slave  (input ld_valid, ld_a, ld_b, output ld_ready);
endinterface

// File: rtl/systolic_feeder.sv
// Buffers L operand columns, then streams them into a row of PEs with a one-step
// skew per lane so lane i sees entry c-i at step c.
//
// state  | meaning
// IDLE   | waiting for start; len latched and clipped to DEPTH
// LOAD   | accepting load beats into buffer entries 0..L-1
// CLEAR  | single cycle; pe_rst_n is driven low in the cycle after it
// STREAM | step counter runs 0..L+LANES-2, one skewed column per step
// DONE   | done pulses in the following cycle, then back to IDLE
module systolic_feeder #(
  parameter int LANES  = 4,
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [$clog2(DEPTH+1)-1:0]  len,
  systolic_feeder_if.slave            ld,
  output logic [LANES*DATA_W-1:0]     out_a,
  output logic [LANES*DATA_W-1:0]     out_b,
  output logic [LANES-1:0]            out_valid,
  output logic                        pe_rst_n,
  output logic                        busy,
  output logic                        done
);

  localparam int LEN_W = $clog2(DEPTH+1);
  localparam int CNT_W = $clog2(DEPTH+LANES);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int VEC_W = LANES*DATA_W;

  typedef enum logic [2:0] {IDLE, LOAD, CLEAR, STREAM, DONE} state_t;

  state_t             state_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   beat_q;
  logic [CNT_W-1:0]   step_q;
  logic [VEC_W-1:0]   mem_a_q [DEPTH];
  logic [VEC_W-1:0]   mem_b_q [DEPTH];
  logic [VEC_W-1:0]   out_a_q, out_a_d;
  logic [VEC_W-1:0]   out_b_q, out_b_d;
  logic [LANES-1:0]   out_valid_q, out_valid_d;
  logic               pe_rst_n_q;
  logic               done_q;
  logic [LEN_W-1:0]   len_clip;
  logic [CNT_W-1:0]   last_step;
  logic               beat_fire;

  assign len_clip  = (len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : len;
  assign beat_fire = ld.ld_valid && (state_q == LOAD);
  assign last_step = CNT_W'(len_q) + CNT_W'(LANES - 1) - CNT_W'(1);

  // Buffer holds no reset: contents only matter for entries written by the current job.
  always_ff @(posedge clk) begin
    if (rst && beat_fire) begin
      mem_a_q[IDX_W'(beat_q)] <= ld.ld_a;
      mem_b_q[IDX_W'(beat_q)] <= ld.ld_b;
    end
  end

  // Range test before subtraction keeps c-i from wrapping into a valid index.
  always_comb begin
    logic [IDX_W-1:0] idx;
    out_a_d     = '0;
    out_b_d     = '0;
    out_valid_d = '0;
    idx         = '0;
    if (state_q == STREAM) begin
      for (int i = 0; i < LANES; i++) begin
        if ((step_q >= CNT_W'(i)) && ((step_q - CNT_W'(i)) < CNT_W'(len_q))) begin
          idx = IDX_W'(step_q - CNT_W'(i));
          out_a_d[i*DATA_W +: DATA_W] = mem_a_q[idx][i*DATA_W +: DATA_W];
          out_b_d[i*DATA_W +: DATA_W] = mem_b_q[idx][i*DATA_W +: DATA_W];
          out_valid_d[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      len_q       <= '0;
      beat_q      <= '0;
      step_q      <= '0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      out_valid_q <= '0;
      pe_rst_n_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
      out_valid_q <= out_valid_d;
      pe_rst_n_q  <= (state_q != CLEAR);
      done_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            len_q   <= len_clip;
            beat_q  <= '0;
            step_q  <= '0;
            state_q <= (len_clip == '0) ? DONE : LOAD;
          end
        end
        LOAD: begin
          if (beat_fire) begin
            beat_q <= beat_q + LEN_W'(1);
            if (beat_q == len_q - LEN_W'(1)) state_q <= CLEAR;
          end
        end
        CLEAR: begin
          step_q  <= '0;
          state_q <= STREAM;
        end
        STREAM: begin
          if (step_q == last_step) state_q <= DONE;
          else                     step_q  <= step_q + CNT_W'(1);
        end
        DONE: begin
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ld.ld_ready = (state_q == LOAD);
  assign busy        = (state_q != IDLE);
  assign out_a       = out_a_q;
  assign out_b       = out_b_q;
  assign out_valid   = out_valid_q;
  assign pe_rst_n    = pe_rst_n_q;
  assign done        = done_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// Scoreboard bench for systolic_feeder: jobs push expected beats, clear pulse,
// skewed steps and done with their cycle numbers; a negedge monitor pops and compares.
module tb_systolic_feeder;
  localparam int LANES  = 4;
  localparam int DEPTH  = 8;
  localparam int DATA_W = 8;
  localparam int VEC_W  = LANES*DATA_W;
  localparam int LEN_W  = $clog2(DEPTH+1);
  localparam int K_BEAT = 0, K_CLR = 1, K_STEP = 2, K_DONE = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic [VEC_W-1:0] out_a, out_b;
  logic [LANES-1:0] out_valid;
  logic             pe_rst_n, busy, done;

  systolic_feeder_if #(.LANES(LANES), .DATA_W(DATA_W)) ld_bus ();

  systolic_feeder #(.LANES(LANES), .DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .ld(ld_bus),
    .out_a(out_a), .out_b(out_b), .out_valid(out_valid),
    .pe_rst_n(pe_rst_n), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst_seen = 1'b1;
  always @(posedge clk) rst_seen <= !rst;

  // PE row model: clears on low pe_rst_n, else accumulates a*b per lane.
  int unsigned psum [LANES];
  always @(posedge clk)
    for (int i = 0; i < LANES; i++)
      if (!pe_rst_n) psum[i] <= 0;
      else psum[i] <= psum[i] + 32'(out_a[i*DATA_W +: DATA_W]) * 32'(out_b[i*DATA_W +: DATA_W]);

  typedef struct {
    int               kind;
    int               cyc;
    logic [VEC_W-1:0] a;
    logic [VEC_W-1:0] b;
    logic [LANES-1:0] v;
  } exp_t;

  exp_t exp_q[$];
  bit   arm = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  function automatic string kname(int k);
    case (k)
      K_BEAT:  return "beat";
      K_CLR:   return "pe_clear";
      K_STEP:  return "step";
      default: return "done";
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] fa(int base, int k, int i);
    return DATA_W'(base + 10*k + i);
  endfunction

  function automatic logic [DATA_W-1:0] fb(int k, int i);
    return DATA_W'(k + 1 + i);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic see_event(input int kind);
    exp_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected %s at cycle %0d", kname(kind), cyc);
    end else if (exp_q[0].kind != kind) begin
      n_fail++;
      $display("FAIL event order at cycle %0d: got %s expected %s", cyc, kname(kind), kname(exp_q[0].kind));
    end else begin
      e = exp_q.pop_front();
      if (e.cyc != cyc) begin
        n_fail++;
        $display("FAIL %s timing: got cycle %0d expected cycle %0d", kname(kind), cyc, e.cyc);
      end else if (kind == K_STEP && (out_a !== e.a || out_b !== e.b || out_valid !== e.v)) begin
        n_fail++;
        $display("FAIL step data at cycle %0d: got a=%h b=%h v=%b expected a=%h b=%h v=%b",
                 cyc, out_a, out_b, out_valid, e.a, e.b, e.v);
      end
    end
  endtask

  always @(negedge clk) begin
    if (arm && !rst_seen) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL missing %s: got nothing by cycle %0d expected at cycle %0d",
                 kname(exp_q[0].kind), cyc, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      if (ld_bus.ld_valid && ld_bus.ld_ready) see_event(K_BEAT);
      if (!pe_rst_n) see_event(K_CLR);
      if (out_valid != '0) see_event(K_STEP);
      else check("idle_operands_zero", 64'(out_a | out_b), 64'd0);
      if (done) see_event(K_DONE);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int kind, input int c, input logic [VEC_W-1:0] a,
                      input logic [VEC_W-1:0] b, input logic [LANES-1:0] v);
    exp_t e;
    e.kind = kind; e.cyc = c; e.a = a; e.b = b; e.v = v;
    exp_q.push_back(e);
  endtask

  // vpat bit j: ld_valid driven in the j-th cycle after start.
  task automatic run_job(input int len_in, input logic [15:0] vpat, input int vn,
                         input int base, input bit restart, input int abort_step);
    int s, l, cnt, jlast, tl, end_cyc, again_rel, kb, d;
    int unsigned dot [LANES];
    logic [VEC_W-1:0] ea, eb, va, vb;
    logic [LANES-1:0] ev;
    s = cyc;
    l = (len_in > DEPTH) ? DEPTH : len_in;
    cnt = 0; jlast = -1; again_rel = -1; tl = 0;
    for (int j = 0; j < vn; j++)
      if (vpat[j]) begin
        if (cnt < l) push(K_BEAT, s + 1 + j, '0, '0, '0);
        if (cnt == l - 1) jlast = j;
        cnt++;
      end
    for (int i = 0; i < LANES; i++) dot[i] = 0;
    if (l == 0) begin
      push(K_DONE, s + 2, '0, '0, '0);
      end_cyc = s + 2;
    end else begin
      tl = s + 1 + jlast;
      push(K_CLR, tl + 2, '0, '0, '0);
      for (int c = 0; c < l + LANES - 1; c++) begin
        if (abort_step >= 0 && c > abort_step) break;
        ea = '0; eb = '0; ev = '0;
        for (int i = 0; i < LANES; i++) begin
          d = c - i;
          if (d >= 0 && d < l) begin
            ea[i*DATA_W +: DATA_W] = fa(base, d, i);
            eb[i*DATA_W +: DATA_W] = fb(d, i);
            ev[i] = 1'b1;
          end
        end
        push(K_STEP, tl + 3 + c, ea, eb, ev);
      end
      for (int k = 0; k < l; k++)
        for (int i = 0; i < LANES; i++) dot[i] += 32'(fa(base, k, i)) * 32'(fb(k, i));
      if (abort_step < 0) begin
        end_cyc = tl + 2 + l + LANES;
        push(K_DONE, end_cyc, '0, '0, '0);
      end else begin
        end_cyc = tl + 3 + abort_step;
      end
      if (restart) again_rel = tl + 4 - s;
    end

    kb = 0;
    for (int r = 0; cyc <= end_cyc; r++) begin
      start = (r == 0) || (r == again_rel);
      len   = (r == 0) ? LEN_W'(len_in) : '0;
      if (r >= 1 && r - 1 < vn && vpat[r-1]) begin
        for (int i = 0; i < LANES; i++) begin
          va[i*DATA_W +: DATA_W] = fa(base, kb, i);
          vb[i*DATA_W +: DATA_W] = fb(kb, i);
        end
        ld_bus.ld_valid = 1'b1; ld_bus.ld_a = va; ld_bus.ld_b = vb;
        kb++;
      end else begin
        ld_bus.ld_valid = 1'b0; ld_bus.ld_a = '0; ld_bus.ld_b = '0;
      end
      if (abort_step >= 0 && cyc == end_cyc) rst = 1'b0;
      if (r == 1) check("busy_after_start", 64'(busy), 64'd1);
      if (abort_step < 0 && cyc == end_cyc) begin
        check("busy_at_done", 64'(busy), 64'd0);
        if (l > 0)
          for (int i = 0; i < LANES; i++) check($sformatf("pe%0d_dot", i), 64'(psum[i]), 64'(dot[i]));
      end
      tick();
    end
    start = 1'b0; len = '0;
    ld_bus.ld_valid = 1'b0; ld_bus.ld_a = '0; ld_bus.ld_b = '0;

    if (abort_step >= 0) begin
      check("abort_out_a", 64'(out_a), 64'd0);
      check("abort_out_b", 64'(out_b), 64'd0);
      check("abort_out_valid", 64'(out_valid), 64'd0);
      check("abort_pe_rst_n", 64'(pe_rst_n), 64'd0);
      check("abort_done", 64'(done), 64'd0);
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_ld_ready", 64'(ld_bus.ld_ready), 64'd0);
      rst = 1'b1;
      tick();
      check("pe_rst_n_after_reset", 64'(pe_rst_n), 64'd1);
      check("no_done_after_abort", 64'(done), 64'd0);
    end
    tick();
  endtask

  initial begin
    ld_bus.ld_valid = 1'b0; ld_bus.ld_a = '0; ld_bus.ld_b = '0;
    rst = 1'b0; start = 1'b1; len = LEN_W'(3);
    repeat (3) tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_ld_ready", 64'(ld_bus.ld_ready), 64'd0);
    check("rst_out_a", 64'(out_a), 64'd0);
    check("rst_out_b", 64'(out_b), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_pe_rst_n", 64'(pe_rst_n), 64'd0);
    rst = 1'b1; start = 1'b0; len = '0;
    tick();
    check("first_edge_pe_rst_n", 64'(pe_rst_n), 64'd1);
    check("start_ignored_in_reset", 64'(busy), 64'd0);
    arm = 1'b1;

    run_job(3,  16'h0007, 3,  0,   1'b0, -1);
    run_job(0,  16'h0007, 3,  0,   1'b0, -1);
    run_job(12, 16'h0FFF, 12, 0,   1'b0, -1);
    run_job(3,  16'h0019, 5,  50,  1'b0, -1);
    run_job(5,  16'h001F, 5,  100, 1'b1, -1);
    run_job(4,  16'h000F, 4,  20,  1'b0, 2);
    run_job(6,  16'h003F, 6,  30,  1'b0, -1);

    repeat (3) tick();
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/systolic_feeder.md
SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 SHALL have parameter LANES, default 4, number of PE lanes driven.
REQ-002 SHALL have parameter DEPTH, default 8, maximum vector length (buffer entries).
REQ-003 SHALL have parameter DATA_W, default 8, operand width per lane.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port start  input  1  begin a job; sampled only in IDLE.
REQ-007 SHALL have port len  input  clog2(DEPTH+1)  vector length, sampled with start.
REQ-008 SHALL have port ld_valid  input  1  load beat valid.
REQ-009 SHALL have port ld_ready  output  1  feeder accepts a load beat.
REQ-010 SHALL have port ld_a  input  LANES*DATA_W  column k of operand A, lane i at bits [i*DATA_W +: DATA_W].
REQ-011 SHALL have port ld_b  input  LANES*DATA_W  column k of operand B, same packing.
REQ-012 SHALL have port out_a  output  LANES*DATA_W  skewed A operands to PE in1 ports.
REQ-013 SHALL have port out_b  output  LANES*DATA_W  skewed B operands to PE in2 ports.
REQ-014 SHALL have port out_valid  output  LANES  per-lane flag: lane carries real data this cycle.
REQ-015 SHALL have port pe_rst_n  output  1  low clears PE psums; high lets PEs accumulate.
REQ-016 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-017 SHALL have port done  output  1  one-cycle pulse at job completion.

Function
REQ-018 SHALL implement FSM states IDLE, LOAD, CLEAR, STREAM, DONE.
REQ-019 SHALL, in IDLE with start=1, latch L = min(len, DEPTH); go to DONE if L=0, else LOAD.
REQ-020 SHALL ignore start in every state other than IDLE.
REQ-021 SHALL drive ld_ready=1 only in LOAD; a beat transfers when ld_valid and ld_ready are both high.
REQ-022 SHALL write beat k (k=0..L-1, in arrival order) into buffer entry k; go to CLEAR on the edge accepting beat L-1.
REQ-023 SHALL, in LOAD, hold count and buffer unchanged on cycles with ld_valid=0.
REQ-024 SHALL stay in CLEAR exactly one cycle, with pe_rst_n registered low during the following cycle; then go to STREAM.
REQ-025 SHALL hold pe_rst_n high in all states except after reset and the CLEAR cycle.
REQ-026 SHALL, in STREAM, run step counter c from 0 to L+LANES-2 (L+LANES-1 cycles), then go to DONE.
REQ-027 SHALL register, for each lane i at step c: if 0<=c-i<L then out_a/out_b lane i = entry[c-i] lane i, out_valid[i]=1; else lane data=0, out_valid[i]=0.
REQ-028 SHALL present step-c outputs in the cycle after the edge on which the FSM is in STREAM with counter c (one-cycle latency).
REQ-029 SHALL drive out_a=0, out_b=0, out_valid=0 whenever no STREAM step is being presented; zero operands leave PE psums unchanged.
REQ-030 SHALL assert done for exactly one cycle in DONE, then return to IDLE; DONE is reached only after the last step's outputs have been presented.
REQ-031 SHALL treat buffer contents as undefined outside the current job; entries at index >= L SHALL never be emitted.
REQ-032 SHALL compute all indices without wrap-around: c-i with c<i is out of range, never a wrapped index.

Reset
REQ-033 SHALL, on any rising clk edge with rst=0, enter IDLE, clear counters, drive ld_ready=0, busy=0, done=0, out_a=0, out_b=0, out_valid=0, pe_rst_n=0.
REQ-034 SHALL abandon any in-progress job on reset without emitting done; the first edge with rst=1 SHALL set pe_rst_n=1.
REQ-035 SHALL ignore start on edges where rst=0.

Verification
REQ-036 Bench SHALL cover: LANES=4, len=3, A lane i = 10k+i -> CLEAR pulse, 6 stream steps, lane 3 valid at steps 3..5 with values 3,13,23, lane 0 valid at steps 0..2, done 1 cycle after the last step.
REQ-037 Bench SHALL cover: len=0 -> no ld_ready, no pe_rst_n pulse, done asserted 2 cycles after start.
REQ-038 Bench SHALL cover: len=12 with DEPTH=8 -> exactly 8 beats accepted, 11 stream steps.
REQ-039 Bench SHALL cover: ld_valid toggling 1,0,0,1,1 with len=3 -> 3 beats stored in order, CLEAR entered after the 3rd accepted beat.
REQ-040 Bench SHALL cover: start pulsed during STREAM -> ignored, single done.
REQ-041 Bench SHALL cover: rst=0 during STREAM step 2 -> next cycle all outputs 0, pe_rst_n=0, no done; a fresh job afterwards completes correctly with 4 PE models checked for expected dot products.
